// File: rtl/falling_object_stepper_if.sv
// Draw/erase request handshake between the falling-object stepper and the VGA drawer.
// The stepper owns the request and the coordinates; the drawer answers with DrawDone.
interface falling_object_stepper_if;
  logic [7:0] ObjX;
  logic [6:0] ObjY;
  logic       DrawReq;
  logic       Erase;
  logic       DrawDone;

  modport master (output ObjX, output ObjY, output DrawReq, output Erase, input DrawDone);
  modport slave  (input ObjX, input ObjY, input DrawReq, input Erase, output DrawDone);
endinterface

// File: rtl/falling_object_stepper.sv
// Steps one falling object down the playfield per rate-divider tick, drives the
// drawer handshake, and judges catch/miss against the paddle at the bottom row.
//
// state | meaning
// IDLE  | waiting for Start
// SPAWN | pick new column from lfsr, row 0
// DRAW  | request paint of object, wait DrawDone
// WAIT  | object drawn, wait for Tick
// ERASE | request paint of background, wait DrawDone
// MOVE  | advance one row
// JUDGE | Hit/Miss pulse visible, mark object as landed
module falling_object_stepper #(
  parameter logic [6:0] ROW_MAX  = 7'd112,
  parameter logic [7:0] PADDLE_W = 8'd16
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Start,
  input  logic                            Tick,
  input  logic [7:0]                      PaddleX,
  falling_object_stepper_if.master        draw,
  output logic                            Hit,
  output logic                            Miss,
  output logic [7:0]                      Score,
  output logic                            Busy
);

  typedef enum logic [2:0] {
    IDLE, SPAWN, DRAW, WAIT, ERASE, MOVE, JUDGE
  } state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] obj_x;
  logic [6:0] obj_y;
  logic       req;
  logic       erase;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic       busy;
  logic       landed;
  logic       caught;

  // 9-bit compare keeps PaddleX + PADDLE_W - 1 from wrapping near column 255.
  assign caught = ({1'b0, PaddleX} <= {1'b0, obj_x}) &&
                  ({1'b0, obj_x} <= ({1'b0, PaddleX} + {1'b0, PADDLE_W} - 9'd1));

  // Hit/Miss and Score are registered on the WAIT->JUDGE edge so the pulse
  // occupies exactly the JUDGE cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      lfsr   <= 8'hA5;
      obj_x  <= 8'd0;
      obj_y  <= 7'd0;
      req    <= 1'b0;
      erase  <= 1'b0;
      hit    <= 1'b0;
      miss   <= 1'b0;
      score  <= 8'd0;
      busy   <= 1'b0;
      landed <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= SPAWN;
            busy  <= 1'b1;
          end
        end
        SPAWN: begin
          obj_x  <= {1'b0, lfsr[6:0]};
          obj_y  <= 7'd0;
          landed <= 1'b0;
          state  <= DRAW;
          req    <= 1'b1;
          erase  <= 1'b0;
        end
        DRAW: begin
          if (draw.DrawDone) begin
            req   <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (Tick) begin
            if (obj_y == ROW_MAX) begin
              state <= JUDGE;
              if (caught) begin
                hit <= 1'b1;
                if (score != 8'hFF) score <= score + 8'd1;
              end else begin
                miss <= 1'b1;
              end
            end else begin
              state <= ERASE;
              req   <= 1'b1;
              erase <= 1'b1;
            end
          end
        end
        ERASE: begin
          if (draw.DrawDone) begin
            req   <= 1'b0;
            erase <= 1'b0;
            state <= landed ? SPAWN : MOVE;
          end
        end
        MOVE: begin
          obj_y <= obj_y + 7'd1;
          state <= DRAW;
          req   <= 1'b1;
          erase <= 1'b0;
        end
        JUDGE: begin
          landed <= 1'b1;
          state  <= ERASE;
          req    <= 1'b1;
          erase  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign draw.ObjX    = obj_x;
  assign draw.ObjY    = obj_y;
  assign draw.DrawReq = req;
  assign draw.Erase   = erase;
  assign Hit          = hit;
  assign Miss         = miss;
  assign Score        = score;
  assign Busy         = busy;

endmodule
